// File: rtl/regulator_lock_controller.sv
// Bring-up and lock supervisor for the ring-oscillator frequency regulator.
// Latches configuration, warms the oscillator, arms the regulator and tracks lock/loss/fault.
module regulator_lock_controller #(
  parameter int WARM_CYCLES    = 32,
  parameter int LOCK_WINDOWS   = 4,
  parameter int MAX_WINDOWS    = 64,
  parameter int UNLOCK_WINDOWS = 2,
  parameter int WIN_TIMEOUT    = 4096
) (
  input  logic       clk_frequency,
  input  logic       rst_frequency,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_setperiod,
  input  logic [7:0] cfg_fmin,
  input  logic [7:0] cfg_fmax,
  input  logic       co_passed_flipflop,
  input  logic       increment,
  input  logic       decrement,
  output logic       osc_en,
  output logic       reg_init,
  output logic [7:0] setperiod,
  output logic [7:0] fmin,
  output logic [7:0] fmax,
  output logic       busy,
  output logic       locked,
  output logic       lost_lock,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] adjust_cnt
);

  localparam int WARM_W = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam int WD_W   = (WIN_TIMEOUT > 1) ? $clog2(WIN_TIMEOUT) : 1;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ACQ  = 2'b01;
  localparam logic [1:0] CODE_DEAD = 2'b10;
  localparam logic [1:0] CODE_CFG  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARM    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [WARM_W-1:0] warm_reg, warm_next;
  logic [7:0]        stable_reg, stable_next;
  logic [7:0]        win_reg, win_next;
  logic [7:0]        miss_reg, miss_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic [7:0]        adjust_reg, adjust_next;
  logic [1:0]        code_reg, code_next;

  logic osc_en_reg, osc_en_next;
  logic reg_init_reg, reg_init_next;
  logic busy_reg, busy_next;
  logic locked_reg, locked_next;
  logic lost_lock_reg, lost_lock_next;
  logic fault_reg, fault_next;

  logic       cfg_load;
  logic       adjusting;
  logic [7:0] adjust_sat;
  logic [7:0] cfg_in [3];

  assign adjusting  = co_passed_flipflop & (increment | decrement);
  assign adjust_sat = (adjust_reg == 8'hFF) ? 8'hFF : adjust_reg + 8'd1;

  assign cfg_in[0] = cfg_setperiod;
  assign cfg_in[1] = cfg_fmin;
  assign cfg_in[2] = cfg_fmax;

  // Configuration fields only load on an honoured start.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cfg
      logic [7:0] field_reg;
      always_ff @(posedge clk_frequency) begin
        if (rst_frequency) begin
          field_reg <= '0;
        end else if (cfg_load) begin
          field_reg <= cfg_in[gi];
        end
      end
    end
  endgenerate

  assign setperiod = g_cfg[0].field_reg;
  assign fmin      = g_cfg[1].field_reg;
  assign fmax      = g_cfg[2].field_reg;

  always_comb begin
    state_next     = state_reg;
    warm_next      = warm_reg;
    stable_next    = stable_reg;
    win_next       = win_reg;
    miss_next      = miss_reg;
    wd_next        = wd_reg;
    adjust_next    = adjust_reg;
    code_next      = code_reg;
    lost_lock_next = 1'b0;
    cfg_load       = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
      code_next  = CODE_NONE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_FAULT: begin
          if (start) begin
            cfg_load    = 1'b1;
            adjust_next = '0;
            // fmax is a frequency limit, so its period must sit below the fmin period
            if (cfg_fmax >= cfg_fmin) begin
              state_next = ST_FAULT;
              code_next  = CODE_CFG;
            end else begin
              state_next = ST_WARM;
              code_next  = CODE_NONE;
              warm_next  = '0;
            end
          end
        end

        ST_WARM: begin
          if (warm_reg == WARM_W'(WARM_CYCLES - 1)) begin
            state_next  = ST_ACQUIRE;
            stable_next = '0;
            win_next    = '0;
            miss_next   = '0;
            wd_next     = '0;
          end else begin
            warm_next = warm_reg + 1'b1;
          end
        end

        ST_ACQUIRE: begin
          if (co_passed_flipflop) begin
            wd_next  = '0;
            win_next = win_reg + 8'd1;
            if (adjusting) begin
              stable_next = '0;
              adjust_next = adjust_sat;
            end else begin
              stable_next = stable_reg + 8'd1;
            end
            // Lock takes precedence when both limits land on the same window
            if (stable_next == 8'(LOCK_WINDOWS)) begin
              state_next = ST_LOCKED;
              miss_next  = '0;
            end else if (win_next == 8'(MAX_WINDOWS)) begin
              state_next = ST_FAULT;
              code_next  = CODE_ACQ;
            end
          end else if (wd_reg == WD_W'(WIN_TIMEOUT - 1)) begin
            state_next = ST_FAULT;
            code_next  = CODE_DEAD;
          end else begin
            wd_next = wd_reg + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (co_passed_flipflop) begin
            wd_next = '0;
            if (adjusting) begin
              miss_next   = miss_reg + 8'd1;
              adjust_next = adjust_sat;
              if (miss_next == 8'(UNLOCK_WINDOWS)) begin
                state_next     = ST_ACQUIRE;
                lost_lock_next = 1'b1;
                stable_next    = '0;
                win_next       = '0;
                miss_next      = '0;
              end
            end else begin
              miss_next = '0;
            end
          end else if (wd_reg == WD_W'(WIN_TIMEOUT - 1)) begin
            state_next = ST_FAULT;
            code_next  = CODE_DEAD;
          end else begin
            wd_next = wd_reg + 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          code_next  = CODE_NONE;
        end
      endcase
    end

    osc_en_next   = (state_next == ST_WARM) || (state_next == ST_ACQUIRE) ||
                    (state_next == ST_LOCKED);
    busy_next     = osc_en_next;
    reg_init_next = (state_next == ST_ACQUIRE) || (state_next == ST_LOCKED);
    locked_next   = (state_next == ST_LOCKED);
    fault_next    = (state_next == ST_FAULT);
  end

  always_ff @(posedge clk_frequency) begin
    if (rst_frequency) begin
      state_reg     <= ST_IDLE;
      warm_reg      <= '0;
      stable_reg    <= '0;
      win_reg       <= '0;
      miss_reg      <= '0;
      wd_reg        <= '0;
      adjust_reg    <= '0;
      code_reg      <= CODE_NONE;
      osc_en_reg    <= 1'b0;
      reg_init_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      locked_reg    <= 1'b0;
      lost_lock_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      warm_reg      <= warm_next;
      stable_reg    <= stable_next;
      win_reg       <= win_next;
      miss_reg      <= miss_next;
      wd_reg        <= wd_next;
      adjust_reg    <= adjust_next;
      code_reg      <= code_next;
      osc_en_reg    <= osc_en_next;
      reg_init_reg  <= reg_init_next;
      busy_reg      <= busy_next;
      locked_reg    <= locked_next;
      lost_lock_reg <= lost_lock_next;
      fault_reg     <= fault_next;
    end
  end

  assign osc_en     = osc_en_reg;
  assign reg_init   = reg_init_reg;
  assign busy       = busy_reg;
  assign locked     = locked_reg;
  assign lost_lock  = lost_lock_reg;
  assign fault      = fault_reg;
  assign fault_code = code_reg;
  assign adjust_cnt = adjust_reg;

endmodule
